// File: rtl/product_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module   : product_bcd_conv
//  Brief    : Serial double-dabble converter from a signed multiplier product
//             to sign + BCD magnitude, one bit per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module product_bcd_conv #(
  parameter int N      = 32,
  parameter int DIGITS = 10
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  iValid,
  input  logic [N-1:0]          iProduct,
  output logic                  oReady,
  output logic                  oValid,
  output logic                  oNeg,
  output logic [4*DIGITS-1:0]   oBCD,
  output logic                  oBusy
);

  localparam int                 C_CNT_W = $clog2(N + 1);
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [N-1:0]          r_mag;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [C_CNT_W-1:0]    r_cnt;
  logic                  r_neg;

  logic [N-1:0]          w_mag_in;
  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_bcd_shift;
  logic                  w_last;

  // Two's-complement negate; the most negative value maps to 2^(N-1) unsigned.
  assign w_mag_in = iProduct[N-1] ? (~iProduct + {{(N-1){1'b0}}, 1'b1}) : iProduct;
  assign w_last   = (r_cnt == C_LAST);

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [3:0] w_dig;
    assign w_dig           = r_bcd[4*d +: 4];
    assign w_adj[4*d +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
  end

  assign w_bcd_shift = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_mag[N-1]};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    oReady       = 1'b0;
    oBusy        = 1'b0;
    oValid       = 1'b0;
    case (r_state)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        oBusy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        oValid       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Published result is only loaded on the final iteration, so it holds
  // the previous conversion throughout IDLE and SHIFT.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mag <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      oBCD  <= '0;
      oNeg  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (iValid) begin
            r_neg <= iProduct[N-1];
            r_mag <= w_mag_in;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_shift;
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            oBCD <= w_bcd_shift;
            oNeg <= r_neg;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_product_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_product_bcd_conv
//  Brief    : Vector table, random products vs. decimal model, busy and
//             mid-conversion reset sequences for product_bcd_conv.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_product_bcd_conv;

  localparam int N      = 32;
  localparam int DIGITS = 10;
  localparam int BW     = 4 * DIGITS;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          iValid = 1'b0;
  logic [N-1:0]  iProduct = '0;
  logic          oReady, oValid, oNeg, oBusy;
  logic [BW-1:0] oBCD;

  int n_cmp = 0;
  int n_err = 0;
  int hold_bad;
  logic [BW-1:0] last_bcd = '0;
  logic          last_neg = 1'b0;

  typedef struct {
    string         name;
    logic [N-1:0]  prod;
    logic          neg;
    logic [BW-1:0] bcd;
  } vec_t;

  vec_t vecs[8];

  product_bcd_conv #(.N(N), .DIGITS(DIGITS)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .iValid   (iValid),
    .iProduct (iProduct),
    .oReady   (oReady),
    .oValid   (oValid),
    .oNeg     (oNeg),
    .oBCD     (oBCD),
    .oBusy    (oBusy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decimal reference: sign and magnitude from plain integer arithmetic.
  function automatic logic [BW-1:0] ref_bcd(input logic [N-1:0] p);
    logic [BW-1:0] r = '0;
    longint v = longint'($signed(p));
    if (v < 0) v = -v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // mode 0: quiet inputs; 1: random iValid/iProduct noise during SHIFT;
  // 2: single iValid pulse with product 7 in the 5th busy cycle.
  task automatic run_conv(input logic [N-1:0] p, input int mode,
                          output int cyc, output bit timed_out, output int ready_bad);
    @(negedge Clock);
    iValid = 1'b1; iProduct = p;
    cyc = 0; timed_out = 1'b1; ready_bad = 0; hold_bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge Clock);
      cyc++;
      @(negedge Clock);
      if (oValid) begin
        timed_out = 1'b0;
        iValid = 1'b0;
        break;
      end
      if (oReady || !oBusy) ready_bad++;
      if (oBCD !== last_bcd || oNeg !== last_neg) hold_bad++;
      case (mode)
        1: begin iValid = 1'($urandom_range(0, 1)); iProduct = $urandom; end
        2: begin iValid = (cyc == 5); iProduct = (cyc == 5) ? 32'd7 : p; end
        default: begin iValid = 1'b0; end
      endcase
    end
  endtask

  task automatic check_conv(input string name, input logic [N-1:0] p,
                            input logic exp_neg, input logic [BW-1:0] exp_bcd, input int mode);
    int cyc, rb;
    bit to;
    run_conv(p, mode, cyc, to, rb);
    chk({name, ".timeout"}, 64'(to), 64'd0);
    chk({name, ".latency"}, 64'(cyc), 64'd33);
    chk({name, ".neg"}, 64'(oNeg), 64'(exp_neg));
    chk({name, ".bcd"}, 64'(oBCD), 64'(exp_bcd));
    chk({name, ".busy_ready"}, 64'(rb), 64'd0);
    chk({name, ".hold"}, 64'(hold_bad), 64'd0);
    last_bcd = exp_bcd;
    last_neg = exp_neg;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [N-1:0] rp;

    vecs[0] = '{"zero",   32'h0000_0000, 1'b0, 40'h00_0000_0000};
    vecs[1] = '{"hundred",32'h0000_0064, 1'b0, 40'h00_0000_0100};
    vecs[2] = '{"minus1", 32'hFFFF_FFFF, 1'b1, 40'h00_0000_0001};
    vecs[3] = '{"minint", 32'h8000_0000, 1'b1, 40'h21_4748_3648};
    vecs[4] = '{"maxint", 32'h7FFF_FFFF, 1'b0, 40'h21_4748_3647};
    vecs[5] = '{"booth",  32'hFFFF_FFEB, 1'b1, 40'h00_0000_0021};
    vecs[6] = '{"nines",  32'h3B9A_C9FF, 1'b0, 40'h09_9999_9999};
    vecs[7] = '{"neg5",   32'hFFFF_FFFB, 1'b1, 40'h00_0000_0005};

    repeat (3) @(negedge Clock);
    chk("rst.ready", 64'(oReady), 64'd1);
    chk("rst.busy",  64'(oBusy),  64'd0);
    chk("rst.valid", 64'(oValid), 64'd0);
    chk("rst.bcd",   64'(oBCD),   64'd0);
    chk("rst.neg",   64'(oNeg),   64'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      check_conv(vecs[i].name, vecs[i].prod, vecs[i].neg, vecs[i].bcd, 0);
    end

    for (int i = 0; i < 40; i++) begin
      rp = $urandom;
      if (i % 4 == 0) rp = N'($urandom_range(0, 999));
      check_conv("rand", rp, rp[N-1], ref_bcd(rp), 1);
    end

    // Busy: a request during SHIFT must be dropped, not queued.
    check_conv("busy", 32'h0000_3039, 1'b0, 40'h00_0001_2345, 2);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (oValid) pulses++;
    end
    chk("busy.extra_valid", 64'(pulses), 64'd0);
    chk("busy.bcd_kept", 64'(oBCD), 64'h00_0001_2345);
    chk("busy.idle_ready", 64'(oReady), 64'd1);

    // Reset in the 10th SHIFT cycle.
    @(negedge Clock);
    iValid = 1'b1; iProduct = 32'h0000_0064;
    @(negedge Clock);
    iValid = 1'b0;
    repeat (9) @(negedge Clock);
    chk("rstmid.in_shift", 64'(oBusy), 64'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rstmid.busy",  64'(oBusy),  64'd0);
    chk("rstmid.ready", 64'(oReady), 64'd1);
    chk("rstmid.bcd",   64'(oBCD),   64'd0);
    chk("rstmid.neg",   64'(oNeg),   64'd0);
    last_bcd = '0;
    last_neg = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (oValid) pulses++;
    end
    chk("rstmid.no_valid", 64'(pulses), 64'd0);
    check_conv("after_rst", 32'h0000_000A, 1'b0, 40'h00_0000_0010, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
